uart_txrx_top: RTL and testbench

//   Full-duplex 8N1 UART that moves 24-bit words as 3-byte packets.
//   The TX path serialises idats on request. The RX path rebuilds 3 received bytes into odats.
//   Top-level serial block; uarttx may be looped to uartrx for self-test.

---
 rtl/uart_txrx_top.sv | 182 ++++++++++++++++++
 tb/tb_uart_txrx_top.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txrx_top.sv
// Full-duplex 8N1 UART carrying 24-bit words as 3-byte packets.
// TX serialises idats MSB byte first; RX reassembles 3 bytes into odats.
module uart_txrx_top #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        uart_tx_req,
  output logic        uart_txs_done,
  input  logic [23:0] idats,
  output logic        uart_rxs_done,
  output logic [23:0] odats,
  output logic        uarttx,
  input  logic        uartrx
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(20 * BAUD_DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [IW-1:0] IDLE_M1 = IW'(20 * BAUD_DIV - 1);
  localparam logic [IW-1:0] I_ONE   = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;

  state_t        tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [1:0]    tx_byte;
  logic [7:0]    tx_sh;
  logic [15:0]   tx_lo;
  logic          tx_tick;

  assign tx_tick = (tx_cnt == DIV_M1);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      tx_st         <= S_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_byte       <= '0;
      tx_sh         <= '0;
      tx_lo         <= '0;
      uarttx        <= 1'b1;
      uart_txs_done <= 1'b0;
    end else begin
      uart_txs_done <= 1'b0;
      if (tx_st != S_IDLE)
        tx_cnt <= tx_tick ? '0 : tx_cnt + C_ONE;
      unique case (tx_st)
        S_IDLE: begin
          uarttx <= 1'b1;
          tx_cnt <= '0;
          if (uart_tx_req) begin
            tx_lo   <= idats[15:0];
            tx_sh   <= idats[23:16];
            tx_byte <= '0;
            uarttx  <= 1'b0;
            tx_st   <= S_START;
          end
        end
        S_START: if (tx_tick) begin
          uarttx <= tx_sh[0];
          tx_bit <= '0;
          tx_st  <= S_DATA;
        end
        S_DATA: if (tx_tick) begin
          if (tx_bit == 3'd7) begin
            uarttx <= 1'b1;
            tx_st  <= S_STOP;
          end else begin
            uarttx <= tx_sh[1];
            tx_sh  <= {1'b0, tx_sh[7:1]};
            tx_bit <= tx_bit + 3'd1;
          end
        end
        S_STOP: if (tx_tick) begin
          if (tx_byte == 2'd2) begin
            uart_txs_done <= 1'b1;
            tx_st         <= S_IDLE;
          end else begin
            tx_byte <= tx_byte + 2'd1;
            tx_sh   <= (tx_byte == 2'd0) ? tx_lo[15:8] : tx_lo[7:0];
            uarttx  <= 1'b0;
            tx_st   <= S_START;
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  state_t        rx_st;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [15:0]   rx_buf;
  logic [1:0]    rx_nbyte;
  logic [IW-1:0] idle_cnt;
  logic          rx_tick;
  logic          rx_fall;

  assign rx_tick = (rx_cnt == DIV_M1);
  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      rx_st         <= S_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_buf        <= '0;
      rx_nbyte      <= '0;
      idle_cnt      <= '0;
      odats         <= '0;
      uart_rxs_done <= 1'b0;
    end else begin
      rx_s1         <= uartrx;
      rx_s2         <= rx_s1;
      rx_prev       <= rx_s2;
      uart_rxs_done <= 1'b0;
      if (rx_st != S_IDLE)
        rx_cnt <= rx_tick ? '0 : rx_cnt + C_ONE;
      // A long idle gap mid-packet realigns to the next packet start.
      if (rx_st == S_IDLE && rx_nbyte != 2'd0 && rx_s2) begin
        if (idle_cnt == IDLE_M1) begin
          idle_cnt <= '0;
          rx_nbyte <= '0;
        end else begin
          idle_cnt <= idle_cnt + I_ONE;
        end
      end else begin
        idle_cnt <= '0;
      end
      unique case (rx_st)
        S_IDLE: begin
          rx_cnt <= '0;
          if (rx_fall)
            rx_st <= S_START;
        end
        S_START: if (rx_cnt == HALF_M1) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_tick) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7)
            rx_st <= S_STOP;
        end
        S_STOP: if (rx_tick) begin
          rx_st <= S_IDLE;
          if (!rx_s2) begin
            rx_nbyte <= '0;
          end else if (rx_nbyte == 2'd2) begin
            odats         <= {rx_buf, rx_sh};
            uart_rxs_done <= 1'b1;
            rx_nbyte      <= '0;
          end else begin
            rx_nbyte <= rx_nbyte + 2'd1;
            if (rx_nbyte == 2'd0)
              rx_buf[15:8] <= rx_sh;
            else
              rx_buf[7:0] <= rx_sh;
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txrx_top.sv
// Directed bench for uart_txrx_top at BAUD_DIV=10 with
// switchable loopback or bench-driven RX line.
module tb_uart_txrx_top;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        uart_tx_req;
  logic [23:0] idats;
  logic        uart_txs_done;
  logic        uart_rxs_done;
  logic [23:0] odats;
  logic        uarttx;
  logic        uartrx;
  logic        loop_en;
  logic        tb_rx;

  always #50 sys_clk = ~sys_clk;

  assign uartrx = loop_en ? uarttx : tb_rx;

  uart_txrx_top #(
    .CLK_FREQ(10_000_000),
    .BAUD    (1_000_000)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .uart_tx_req  (uart_tx_req),
    .uart_txs_done(uart_txs_done),
    .idats        (idats),
    .uart_rxs_done(uart_rxs_done),
    .odats        (odats),
    .uarttx       (uarttx),
    .uartrx       (uartrx)
  );

  int tests = 0;
  int fails = 0;
  int tx_n  = 0;
  int rx_n  = 0;
  logic [23:0] rx_words[$];

  always @(negedge sys_clk) begin
    if (uart_txs_done) tx_n++;
    if (uart_rxs_done) begin
      rx_n++;
      rx_words.push_back(odats);
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int target, input int budget,
                         output int cyc);
    cyc = 0;
    while (tx_n < target && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_rx(input int target, input int budget,
                         output int cyc);
    cyc = 0;
    while (rx_n < target && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic send_bit(input logic v);
    tb_rx = v;
    repeat (10) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    int c;
    int txb;
    int rxb;
    logic [29:0] exp_bits;
    logic [29:0] got_bits;
    logic [23:0] w;
    logic [7:0]  bb;
    logic [23:0] exp_words [3];

    loop_en = 1'b1;
    tb_rx = 1'b1;
    rst_n = 1'b0;
    uart_tx_req = 1'b0;
    idats = '0;

    // Reset
    tick();
    tick();
    check("rst_uarttx", uarttx, 1);
    check("rst_txs_done", uart_txs_done, 0);
    check("rst_rxs_done", uart_rxs_done, 0);
    check("rst_odats", odats, 0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("idle_line", uarttx, 1);
    check("idle_no_pulses", tx_n + rx_n, 0);

    // Single packet, serial waveform sampled at bit centres
    w = 24'h002FE0;
    for (int by = 0; by < 3; by++) begin
      bb = w[23 - 8 * by -: 8];
      exp_bits[by * 10] = 1'b0;
      for (int k = 0; k < 8; k++) exp_bits[by * 10 + 1 + k] = bb[k];
      exp_bits[by * 10 + 9] = 1'b1;
    end
    idats = w;
    uart_tx_req = 1'b1;
    tick();
    uart_tx_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      repeat ((i == 0) ? 5 : 10) tick();
      got_bits[i] = uarttx;
    end
    check("tx_frame_bits", got_bits, exp_bits);
    wait_tx(1, 20, c);
    check("tx_done_seen", tx_n, 1);
    check("tx_packet_len", c, 5);
    check("tx_done_high", uart_txs_done, 1);
    tick();
    check("tx_done_pulse", uart_txs_done, 0);
    wait_rx(1, 100, c);
    check("rx_done_seen", rx_n, 1);
    check("rx_single_word", odats, 24'h002FE0);

    // Streaming with req held high
    txb = tx_n;
    rxb = rx_n;
    exp_words[0] = 24'h002FE0;
    exp_words[1] = 24'h0038F3;
    exp_words[2] = 24'h004206;
    idats = 24'h002FE0;
    uart_tx_req = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_tx(txb + p + 1, 400, c);
      check("stream_tx_done", tx_n, txb + p + 1);
      if (p > 0) check("stream_gap", (c >= 300 && c <= 302), 1);
      idats = idats + 24'd2323;
      if (p == 2) uart_tx_req = 1'b0;
    end
    wait_rx(rxb + 3, 100, c);
    check("stream_rx_count", rx_n, rxb + 3);
    for (int i = 0; i < 3; i++)
      check("stream_word", rx_words[rxb + i], exp_words[i]);
    repeat (400) tick();
    check("stream_no_extra_tx", tx_n, txb + 3);
    check("stream_no_extra_rx", rx_n, rxb + 3);

    // Framing error then valid packet on a bench-driven line
    loop_en = 1'b0;
    repeat (5) tick();
    rxb = rx_n;
    send_byte(8'h55, 1'b0);
    tb_rx = 1'b1;
    repeat (30) tick();
    check("frame_err_no_pulse", rx_n, rxb);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
    repeat (20) tick();
    check("frame_err_count", rx_n, rxb + 1);
    check("frame_err_word", odats, 24'hABCDEF);

    // Partial packet followed by a long idle gap
    rxb = rx_n;
    send_byte(8'h11, 1'b1);
    tb_rx = 1'b1;
    repeat (300) tick();
    check("resync_no_pulse", rx_n, rxb);
    check("resync_hold", odats, 24'hABCDEF);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (20) tick();
    check("resync_count", rx_n, rxb + 1);
    check("resync_word", odats, 24'h223344);

    // Short glitch on the idle line
    rxb = rx_n;
    tb_rx = 1'b0;
    repeat (2) tick();
    tb_rx = 1'b1;
    repeat (30) tick();
    check("glitch_no_pulse", rx_n, rxb);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    repeat (20) tick();
    check("glitch_count", rx_n, rxb + 1);
    check("glitch_word", odats, 24'h123456);

    // Reset during byte 1 of a transmit, then restart
    loop_en = 1'b1;
    repeat (5) tick();
    idats = 24'hC3A55A;
    uart_tx_req = 1'b1;
    repeat (150) tick();
    txb = tx_n;
    rxb = rx_n;
    rst_n = 1'b0;
    tick();
    check("midrst_uarttx", uarttx, 1);
    check("midrst_txs_done", uart_txs_done, 0);
    check("midrst_rxs_done", uart_rxs_done, 0);
    check("midrst_odats", odats, 0);
    tick();
    check("midrst_no_tx_pulse", tx_n, txb);
    check("midrst_no_rx_pulse", rx_n, rxb);
    rst_n = 1'b1;
    repeat (3) tick();
    uart_tx_req = 1'b0;
    wait_tx(txb + 1, 400, c);
    check("restart_tx_done", tx_n, txb + 1);
    check("restart_len", c, 298);
    wait_rx(rxb + 1, 100, c);
    check("restart_rx_count", rx_n, rxb + 1);
    check("restart_word", odats, 24'hC3A55A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
